// File: rtl/display_sel_ctrl.sv
// display_sel_ctrl: pushbutton front end for the 7-segment debug display.
// Synchronises and debounces the next/prev/reg buttons, turns accepted
// presses into one-cycle pulses, and drives the wrapping view selector and
// register index consumed by the display path.
// Optional feature: define AUTOSCAN_EN to make sel auto-advance every
// AUTOSCAN_CYCLES cycles of press inactivity.
module display_sel_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int NUM_VIEWS       = 6,
   parameter int AUTOSCAN_CYCLES = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_next_raw,
   input  logic       btn_prev_raw,
   input  logic       btn_reg_raw,
   output logic [2:0] sel,
   output logic [4:0] reg_idx,
   output logic       sel_changed
);

   // Views in display order; only the first NUM_VIEWS are reachable.
   typedef enum logic [2:0] {
      VIEW_PC_LO   = 3'd0,
      VIEW_PC_HI   = 3'd1,
      VIEW_REG_LO  = 3'd2,
      VIEW_REG_HI  = 3'd3,
      VIEW_INSN_LO = 3'd4,
      VIEW_INSN_HI = 3'd5,
      VIEW_AUX6    = 3'd6,
      VIEW_AUX7    = 3'd7
   } view_t;

   localparam int             CW        = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
   localparam view_t          VIEW_LAST = view_t'(3'(NUM_VIEWS - 1));

   // Elaboration-time guards on the parameter ranges the logic relies on.
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("display_sel_ctrl: DEBOUNCE_CYCLES must be at least 2");
   end
   if (NUM_VIEWS < 1 || NUM_VIEWS > 8) begin : g_bad_views
      $error("display_sel_ctrl: NUM_VIEWS must be in 1..8");
   end
   if (AUTOSCAN_CYCLES < 1) begin : g_bad_autoscan
      $error("display_sel_ctrl: AUTOSCAN_CYCLES must be positive");
   end

   // Button vector layout: bit 0 next, bit 1 prev, bit 2 reg.
   logic [2:0]    raw;
   logic [2:0]    sync1;
   logic [2:0]    sync2;
   logic [2:0]    deb;
   logic [2:0]    deb_d;
   logic [2:0]    armed;
   logic [2:0]    press;
   logic [CW-1:0] db_cnt [3];

   logic          any_press;
   logic          auto_tick;

   view_t         state;
   view_t         state_next;
   logic [4:0]    reg_next;
   logic          changed;

   assign raw       = {btn_reg_raw, btn_prev_raw, btn_next_raw};
   assign any_press = |press;

   // Two-flop synchronisers bring the asynchronous buttons into the clk domain.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Debouncers: accept a new level only after it has been stable long enough.
   // A button is only armed once it has been seen released for a full debounce
   // window, so a button held through reset cannot generate a press.
   always_ff @(posedge clk) begin
      if (rst) begin
         deb   <= '0;
         armed <= '0;
         for (int i = 0; i < 3; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] != deb[i]) begin
               if (db_cnt[i] == DB_LAST) begin
                  deb[i]    <= sync2[i];
                  db_cnt[i] <= '0;
                  if (!sync2[i]) begin
                     armed[i] <= 1'b1;
                  end
               end else begin
                  db_cnt[i] <= db_cnt[i] + CW'(1);
               end
            end else if (!armed[i] && !sync2[i]) begin
               if (db_cnt[i] == DB_LAST) begin
                  armed[i]  <= 1'b1;
                  db_cnt[i] <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + CW'(1);
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   // Registered rising-edge detect on the debounced levels gives press pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         deb_d <= '0;
         press <= '0;
      end else begin
         deb_d <= deb;
         press <= deb & ~deb_d & armed;
      end
   end

`ifdef AUTOSCAN_EN
   localparam int            AW        = (AUTOSCAN_CYCLES > 1) ? $clog2(AUTOSCAN_CYCLES) : 1;
   localparam logic [AW-1:0] AUTO_LAST = AW'(AUTOSCAN_CYCLES - 1);

   logic [AW-1:0] auto_cnt;

   // Free-running auto-advance timer, restarted by any accepted press.
   always_ff @(posedge clk) begin
      if (rst) begin
         auto_cnt <= '0;
      end else if (any_press || auto_cnt == AUTO_LAST) begin
         auto_cnt <= '0;
      end else begin
         auto_cnt <= auto_cnt + AW'(1);
      end
   end

   assign auto_tick = (auto_cnt == AUTO_LAST) && !any_press;
`else
   assign auto_tick = 1'b0;
`endif

   // View/register state register; sel_changed is the registered change flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= VIEW_PC_LO;
         reg_idx     <= '0;
         sel_changed <= 1'b0;
      end else begin
         state       <= state_next;
         reg_idx     <= reg_next;
         sel_changed <= changed;
      end
   end

   // Next view and register index; opposing next/prev cancel, and register
   // stepping is gated on the view in effect before this update.
   always_comb begin
      state_next = state;
      reg_next   = reg_idx;
      changed    = 1'b0;

      if ((press[0] || auto_tick) && !press[1]) begin
         state_next = (state == VIEW_LAST) ? VIEW_PC_LO : view_t'(state + 3'd1);
      end else if (press[1] && !(press[0] || auto_tick)) begin
         state_next = (state == VIEW_PC_LO) ? VIEW_LAST : view_t'(state - 3'd1);
      end

      if (press[2] && (state == VIEW_REG_LO || state == VIEW_REG_HI)) begin
         reg_next = reg_idx + 5'd1;
      end

      changed = (state_next != state) || (reg_next != reg_idx);
   end

   assign sel = state;

endmodule

// File: tb/tb_display_sel_ctrl.sv
// tb_display_sel_ctrl: directed self-checking bench for display_sel_ctrl,
// built with DEBOUNCE_CYCLES=4, NUM_VIEWS=6, AUTOSCAN_CYCLES=20 and the
// default (AUTOSCAN_EN undefined) configuration.
module tb_display_sel_ctrl;

   logic       clk;
   logic       rst;
   logic       btn_next_raw;
   logic       btn_prev_raw;
   logic       btn_reg_raw;
   logic [2:0] sel;
   logic [4:0] reg_idx;
   logic       sel_changed;

   int checks;
   int errors;
   int pulse_count;
   int pulses_before;

   display_sel_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .NUM_VIEWS       (6),
      .AUTOSCAN_CYCLES (20)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btn_next_raw (btn_next_raw),
      .btn_prev_raw (btn_prev_raw),
      .btn_reg_raw  (btn_reg_raw),
      .sel          (sel),
      .reg_idx      (reg_idx),
      .sel_changed  (sel_changed)
   );

   // 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count sel_changed pulses, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst && sel_changed) begin
         pulse_count++;
      end
   end

   // Single comparison point: counts the check and reports a mismatch.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Advance n rising edges and settle 1ns after the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Hold the masked buttons ({reg,prev,next}) high, then release and let
   // the debouncers settle low again.
   task automatic applyStimulus(input logic [2:0] mask, input int high_cycles);
      {btn_reg_raw, btn_prev_raw, btn_next_raw} = mask;
      tick(high_cycles);
      {btn_reg_raw, btn_prev_raw, btn_next_raw} = 3'b000;
      tick(12);
   endtask

   task automatic doReset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      pulse_count  = 0;
      rst          = 1'b0;
      btn_next_raw = 1'b0;
      btn_prev_raw = 1'b0;
      btn_reg_raw  = 1'b0;
      @(posedge clk);
      #1;

      // 1: reset values and exact press latency
      doReset();
      checkOutput("reset_sel", sel, 0);
      checkOutput("reset_reg_idx", reg_idx, 0);
      checkOutput("reset_sel_changed", sel_changed, 0);
      tick(10);
      pulses_before = pulse_count;
      btn_next_raw = 1'b1;
      tick(7);
      checkOutput("latency_sel_before", sel, 0);
      checkOutput("latency_changed_before", sel_changed, 0);
      tick(1);
      checkOutput("latency_sel_at_edge7", sel, 1);
      checkOutput("latency_changed_pulse", sel_changed, 1);
      tick(1);
      checkOutput("latency_changed_drop", sel_changed, 0);
      btn_next_raw = 1'b0;
      tick(12);
      checkOutput("latency_pulse_count", pulse_count - pulses_before, 1);

      // 2: short glitches are rejected, a clean press is accepted once
      pulses_before = pulse_count;
      for (int w = 1; w <= 3; w++) begin
         btn_next_raw = 1'b1;
         tick(w);
         btn_next_raw = 1'b0;
         tick(3);
      end
      tick(8);
      checkOutput("glitch_sel", sel, 1);
      checkOutput("glitch_pulses", pulse_count - pulses_before, 0);
      applyStimulus(3'b001, 10);
      checkOutput("clean_after_bounce_sel", sel, 2);
      checkOutput("clean_after_bounce_pulses", pulse_count - pulses_before, 1);

      // 3: prev wraps 0 -> 5, next walks 5 -> 0 .. 5
      doReset();
      checkOutput("reset2_sel", sel, 0);
      tick(10);
      applyStimulus(3'b010, 10);
      checkOutput("prev_wrap_sel", sel, 5);
      for (int k = 0; k < 6; k++) begin
         applyStimulus(3'b001, 10);
         checkOutput($sformatf("next_walk_%0d", k), sel, k);
      end

      // 4: next and prev together cancel
      pulses_before = pulse_count;
      applyStimulus(3'b011, 10);
      checkOutput("next_prev_sel", sel, 5);
      checkOutput("next_prev_pulses", pulse_count - pulses_before, 0);

      // 5: register index stepping, wrap and view gating
      applyStimulus(3'b001, 10);
      applyStimulus(3'b001, 10);
      applyStimulus(3'b001, 10);
      checkOutput("reg_view_sel", sel, 2);
      pulses_before = pulse_count;
      for (int k = 0; k < 31; k++) begin
         applyStimulus(3'b100, 10);
      end
      checkOutput("reg_idx_31", reg_idx, 31);
      applyStimulus(3'b100, 10);
      checkOutput("reg_idx_wrap", reg_idx, 0);
      applyStimulus(3'b100, 10);
      checkOutput("reg_idx_33", reg_idx, 1);
      checkOutput("reg_pulses", pulse_count - pulses_before, 33);
      applyStimulus(3'b101, 10);
      checkOutput("next_reg_sel", sel, 3);
      checkOutput("next_reg_idx", reg_idx, 2);
      applyStimulus(3'b101, 10);
      checkOutput("next_reg2_sel", sel, 4);
      checkOutput("next_reg2_idx", reg_idx, 3);
      pulses_before = pulse_count;
      applyStimulus(3'b100, 10);
      checkOutput("reg_ignored_idx", reg_idx, 3);
      checkOutput("reg_ignored_pulses", pulse_count - pulses_before, 0);
      applyStimulus(3'b110, 10);
      checkOutput("prev_reg_sel", sel, 3);
      checkOutput("prev_reg_idx", reg_idx, 3);

      // 6: reset while next is held; no press until released and re-pressed
      btn_next_raw = 1'b1;
      tick(20);
      checkOutput("held_before_reset_sel", sel, 4);
      doReset();
      checkOutput("held_reset_sel", sel, 0);
      checkOutput("held_reset_reg_idx", reg_idx, 0);
      pulses_before = pulse_count;
      tick(30);
      checkOutput("held_after_reset_sel", sel, 0);
      checkOutput("held_after_reset_pulses", pulse_count - pulses_before, 0);
      btn_next_raw = 1'b0;
      tick(12);
      checkOutput("released_sel", sel, 0);
      applyStimulus(3'b001, 10);
      checkOutput("repress_sel", sel, 1);
      checkOutput("repress_pulses", pulse_count - pulses_before, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
